// File: rtl/mips_instr_encoder.sv
//==============================================================================
// mips_instr_encoder : encodes mnemonic+field requests into 32-bit MIPS words,
//   buffers them in a FIFO and writes them to instruction memory at consecutive
//   word addresses. Optional macro: MIPS_ENC_SEXT_CHECK_EN (immediate range check).
// Revision: 1.0
//==============================================================================
`default_nettype none

module mips_instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
`ifdef MIPS_ENC_SEXT_CHECK_EN
  input  logic [15:0]       in_imm_hi,
`endif
  input  logic [25:0]       in_target,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [15:0]       count
);

  localparam int unsigned    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_SLL   = 5'd10;
  localparam logic [4:0] OP_SRL   = 5'd11;
  localparam logic [4:0] OP_SRA   = 5'd12;
  localparam logic [4:0] OP_SLLV  = 5'd13;
  localparam logic [4:0] OP_SRLV  = 5'd14;
  localparam logic [4:0] OP_SRAV  = 5'd15;
  localparam logic [4:0] OP_JR    = 5'd16;
  localparam logic [4:0] OP_LW    = 5'd17;
  localparam logic [4:0] OP_SW    = 5'd18;
  localparam logic [4:0] OP_BEQ   = 5'd19;
  localparam logic [4:0] OP_BNE   = 5'd20;
  localparam logic [4:0] OP_ADDI  = 5'd21;
  localparam logic [4:0] OP_ADDIU = 5'd22;
  localparam logic [4:0] OP_ANDI  = 5'd23;
  localparam logic [4:0] OP_ORI   = 5'd24;
  localparam logic [4:0] OP_XORI  = 5'd25;
  localparam logic [4:0] OP_SLTI  = 5'd26;
  localparam logic [4:0] OP_SLTIU = 5'd27;
  localparam logic [4:0] OP_J     = 5'd28;
  localparam logic [4:0] OP_JAL   = 5'd29;
  localparam logic [4:0] OP_LUI   = 5'd30;

  // ---------------------------------------------------------------- encoder
  logic        is_r;
  logic        is_j;
  logic        legal;
  logic        shift_imm;
  logic        sext_op;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_f;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  sh_f;
  logic [31:0] enc_word;

  always_comb begin
    is_r    = 1'b0;
    is_j    = 1'b0;
    legal   = 1'b1;
    sext_op = 1'b0;
    opcode  = 6'h00;
    funct   = 6'h00;
    case (in_op)
      OP_ADD:   begin is_r = 1'b1; funct = 6'h20; end
      OP_ADDU:  begin is_r = 1'b1; funct = 6'h21; end
      OP_SUB:   begin is_r = 1'b1; funct = 6'h22; end
      OP_SUBU:  begin is_r = 1'b1; funct = 6'h23; end
      OP_AND:   begin is_r = 1'b1; funct = 6'h24; end
      OP_OR:    begin is_r = 1'b1; funct = 6'h25; end
      OP_XOR:   begin is_r = 1'b1; funct = 6'h26; end
      OP_NOR:   begin is_r = 1'b1; funct = 6'h27; end
      OP_SLT:   begin is_r = 1'b1; funct = 6'h2A; end
      OP_SLTU:  begin is_r = 1'b1; funct = 6'h2B; end
      OP_SLL:   begin is_r = 1'b1; funct = 6'h00; end
      OP_SRL:   begin is_r = 1'b1; funct = 6'h02; end
      OP_SRA:   begin is_r = 1'b1; funct = 6'h03; end
      OP_SLLV:  begin is_r = 1'b1; funct = 6'h04; end
      OP_SRLV:  begin is_r = 1'b1; funct = 6'h06; end
      OP_SRAV:  begin is_r = 1'b1; funct = 6'h07; end
      OP_JR:    begin is_r = 1'b1; funct = 6'h08; end
      OP_LW:    begin opcode = 6'h23; sext_op = 1'b1; end
      OP_SW:    begin opcode = 6'h2B; sext_op = 1'b1; end
      OP_BEQ:   begin opcode = 6'h04; sext_op = 1'b1; end
      OP_BNE:   begin opcode = 6'h05; sext_op = 1'b1; end
      OP_ADDI:  begin opcode = 6'h08; sext_op = 1'b1; end
      OP_ADDIU: begin opcode = 6'h09; sext_op = 1'b1; end
      OP_ANDI:  opcode = 6'h0C;
      OP_ORI:   opcode = 6'h0D;
      OP_XORI:  opcode = 6'h0E;
      OP_SLTI:  begin opcode = 6'h0A; sext_op = 1'b1; end
      OP_SLTIU: begin opcode = 6'h0B; sext_op = 1'b1; end
      OP_J:     begin is_j = 1'b1; opcode = 6'h02; end
      OP_JAL:   begin is_j = 1'b1; opcode = 6'h03; end
      OP_LUI:   opcode = 6'h0F;
      default:  legal = 1'b0;
    endcase
`ifdef MIPS_ENC_SEXT_CHECK_EN
    // Immediate must be the sign-extended form of the intended 32-bit value.
    if (sext_op && (in_imm_hi != {16{in_imm[15]}})) begin
      legal = 1'b0;
    end
`endif
  end

  always_comb begin
    shift_imm = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
    rs_f      = (shift_imm || (in_op == OP_LUI)) ? 5'd0 : in_rs;
    rt_f      = (in_op == OP_JR) ? 5'd0 : in_rt;
    rd_f      = (in_op == OP_JR) ? 5'd0 : in_rd;
    sh_f      = shift_imm ? in_shamt : 5'd0;
    if (is_r) begin
      enc_word = {6'h00, rs_f, rt_f, rd_f, sh_f, funct};
    end else if (is_j) begin
      enc_word = {opcode, in_target};
    end else begin
      enc_word = {opcode, rs_f, rt_f, in_imm};
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [31:0]      fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W:0]   occ_q;
  logic [PTR_W:0]   occ_d;
  logic             full;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop;

  assign full     = (occ_q == C_DEPTH);
  assign empty    = (occ_q == '0);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = !empty && mem_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= enc_word;
    end
  end

  // ---------------------------------------------------------------- write side
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       count_q;
  logic [15:0]       count_d;
  logic              err_q;
  logic              unused_ok;

  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (base_load) begin
      addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
      count_d = 16'd0;
    end else if (pop) begin
      addr_d  = addr_q + ADDR_W'(4);
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= accept && !legal;
    end
  end

  assign unused_ok = ^base_addr[1:0];
  assign mem_we    = !empty;
  assign mem_addr  = addr_q;
  assign mem_wdata = empty ? 32'h0 : fifo_q[rd_ptr_q];
  assign err       = err_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
//==============================================================================
// tb_mips_instr_encoder : directed self-checking bench for mips_instr_encoder.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_mips_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              err;
  logic [15:0]       count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          occ      = 0;
  logic        mon_en   = 1'b0;
  logic [31:0] cap_addr [$];
  logic [31:0] cap_data [$];

  always #5 clk = ~clk;

  mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
`ifdef MIPS_ENC_SEXT_CHECK_EN
    .in_imm_hi ({16{in_imm[15]}}),
`endif
    .in_target (in_target),
    .base_load (base_load),
    .base_addr (base_addr),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .err       (err),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Occupancy model: handshake legality and write strobe every cycle, capture completed writes.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready_model", in_ready, occ != DEPTH);
      check("mem_we_model", mem_we, occ != 0);
      if (reset) begin
        occ <= 0;
      end else begin
        occ <= occ + ((in_valid && in_ready && in_op != 5'd31) ? 1 : 0)
                   - ((mem_we && mem_ready) ? 1 : 0);
        if (mem_we && mem_ready) begin
          cap_addr.push_back(mem_addr);
          cap_data.push_back(mem_wdata);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_base(input logic [31:0] a);
    base_load = 1'b1;
    base_addr = a;
    @(posedge clk);
    #1;
    base_load = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt);
    bit got;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; in_target = '0; base_load = 1'b0; base_addr = '0;
    mem_ready = 1'b1;
    idle(2);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    mon_en = 1'b1;

    // ADD with nonzero shamt request: shamt forced to 0
    load_base(32'h400);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0);
    check("add_we", mem_we, 1);
    check("add_wdata", mem_wdata, 32'h00221820);
    check("add_addr", mem_addr, 32'h400);
    idle(1);
    check("add_count", count, 1);
    check("add_addr_next", mem_addr, 32'h404);

    // LW, SLL (rs forced 0), JR (rt/rd/shamt forced 0), LUI (rs forced 0)
    load_base(32'h0);
    clear_cap();
    send(5'd17, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    send(5'd10, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
    send(5'd16, 5'd31, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
    send(5'd30, 5'd5, 5'd6, 5'd0, 5'd0, 16'hABCD, 26'h0);
    idle(3);
    check("seq1_len", cap_data.size(), 4);
    check("lw_word", cap_data[0], 32'h8FA80004);
    check("lw_addr", cap_addr[0], 32'h0);
    check("sll_word", cap_data[1], 32'h00011100);
    check("sll_addr", cap_addr[1], 32'h4);
    check("jr_word", cap_data[2], 32'h03E00008);
    check("lui_word", cap_data[3], 32'h3C06ABCD);
    check("lui_addr", cap_addr[3], 32'hC);

    // BNE then J at consecutive addresses
    clear_cap();
    send(5'd20, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    send(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
    idle(3);
    check("seq2_len", cap_data.size(), 2);
    check("bne_word", cap_data[0], 32'h1422FFFF);
    check("bne_addr", cap_addr[0], 32'h10);
    check("j_word", cap_data[1], 32'h08000040);
    check("j_addr", cap_addr[1], 32'h14);
    check("seq2_count", count, 6);

    // Stall memory, fill FIFO, one extra request must wait without loss
    mem_ready = 1'b0;
    load_base(32'h100);
    clear_cap();
    for (int k = 1; k <= DEPTH; k++) send(5'd21, 5'd0, 5'(k), 5'd0, 5'd0, 16'(k), 26'h0);
    check("full_in_ready", in_ready, 0);
    in_op = 5'd21; in_rs = 5'd0; in_rt = 5'(DEPTH + 1); in_imm = 16'(DEPTH + 1);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_wdata", mem_wdata, 32'h20010001);
      check("stall_addr", mem_addr, 32'h100);
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    send(5'd21, 5'd0, 5'(DEPTH + 1), 5'd0, 5'd0, 16'(DEPTH + 1), 26'h0);
    idle(10);
    check("stall_len", cap_data.size(), DEPTH + 1);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      check("stall_word", cap_data[k-1], 32'h20000000 | (32'(k) << 16) | 32'(k));
      check("stall_waddr", cap_addr[k-1], 32'h100 + 32'((k - 1) * 4));
    end
    check("stall_count", count, DEPTH + 1);

    // Address wrap (low bits of base ignored), then an illegal op
    load_base(32'hFFFF_FFFE);
    clear_cap();
    send(5'd24, 5'd3, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0);
    send(5'd29, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF);
    idle(3);
    check("wrap_len", cap_data.size(), 2);
    check("ori_word", cap_data[0], 32'h34641234);
    check("ori_addr", cap_addr[0], 32'hFFFF_FFFC);
    check("jal_word", cap_data[1], 32'h0FFF_FFFF);
    check("jal_addr", cap_addr[1], 32'h0);
    clear_cap();
    send(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    check("err_pulse", err, 1);
    check("err_no_we", mem_we, 0);
    idle(1);
    check("err_clear", err, 0);
    idle(3);
    check("illegal_len", cap_data.size(), 0);
    check("illegal_count", count, 2);

    // Reset with words queued flushes everything
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(5'd1, 5'(k), 5'(k), 5'(k), 5'd0, 16'h0, 26'h0);
    check("pre_rst_we", mem_we, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("flush_we", mem_we, 0);
    check("flush_count", count, 0);
    check("flush_addr", mem_addr, 0);
    check("flush_in_ready", in_ready, 1);
    mem_ready = 1'b1;
    idle(5);
    check("flush_len", cap_data.size(), 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
